sa_result_drain: RTL and testbench

Output-side counterpart to the systolic-array operand feed bus. The feed bus carries BUS_WIDTH = 2*DIN_WIDTH*N operand bits per beat into an SA. This block captures the M x N accumulator matrix when the SA signals completion. It then streams the matrix out one row per beat over a valid/ready bus, saturating each accumulator to the output element width. One instance sits beside each SA in the subsystem (NUM_SA instances).

---
 rtl/sa_result_drain_pkg.sv | 29 ++
 rtl/sa_sat.sv | 39 +++
 rtl/sa_result_drain.sv | 133 +++++++++++++
 tb/tb_sa_result_drain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_result_drain_pkg.sv
// Shared package for the systolic-array subsystem result path.
// Holds the per-instance widths for the two SA instances, the drain FSM
// state encoding, and a helper that sizes the row-index port.
package sa_result_drain_pkg;

  // Operand width feeding every SA in the subsystem.
  localparam int DIN_WIDTH_SA = 8;

  // Instance 0: reduction depth up to 16.
  localparam int K_MAX_0      = 16;
  localparam int ACC_WIDTH_0  = 2 * DIN_WIDTH_SA + $clog2(K_MAX_0);
  localparam int OUT_WIDTH_0  = 2 * DIN_WIDTH_SA;

  // Instance 1: reduction depth up to 32.
  localparam int K_MAX_1      = 32;
  localparam int ACC_WIDTH_1  = 2 * DIN_WIDTH_SA + $clog2(K_MAX_1);
  localparam int OUT_WIDTH_1  = 2 * DIN_WIDTH_SA;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // A row index always needs at least one bit, even for a single-row array.
  function automatic int row_idx_width(int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sa_sat.sv
// Signed saturation of one accumulator to the output element width.
// Purely combinational.
//   acc : ACC_WIDTH-bit signed accumulator
//   sat : OUT_WIDTH-bit signed result, clipped to the representable range
module sa_sat #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] sat
);

  generate
    if (OUT_WIDTH >= ACC_WIDTH) begin : g_extend
      // Output is wide enough for every accumulator value: sign-extend only.
      logic signed [OUT_WIDTH-1:0] ext;
      assign ext = $signed(acc);
      assign sat = ext;
    end else begin : g_clip
      // Output-range limits expressed at accumulator width for the compare.
      localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
      localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

      // NOTE: every output of a combinational block gets a default first so
      // no path through the if-chain leaves it unassigned (no latch).
      always_comb begin
        sat = acc[OUT_WIDTH-1:0];
        if ($signed(acc) > MAX_V) begin
          sat = MAX_V[OUT_WIDTH-1:0];
        end else if ($signed(acc) < MIN_V) begin
          sat = MIN_V[OUT_WIDTH-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sa_result_drain.sv
// Result drain for one systolic array.
// Captures the M x N accumulator matrix when the SA reports completion and
// streams it out one saturated row per beat over a valid/ready interface.
//   clk, rst    : single clock, synchronous active-high reset
//   i_sa_done   : one-cycle pulse, accumulators on i_sa_acc are final
//   i_sa_acc    : flattened accumulators, (r,c) at (r*N+c)*ACC_WIDTH
//   o_sa_hold   : a matrix is held/draining; SA must not start a new job
//   o_valid     : output beat valid
//   i_ready     : downstream accepts the beat
//   o_data      : saturated row, column c at c*OUT_WIDTH
//   o_row       : row index of the current beat
//   o_last      : current beat carries row M-1
//   o_overrun   : sticky, a done pulse arrived while busy and was dropped
//   i_clr_err   : clears o_overrun (a new overrun in the same cycle wins)
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int N             = 2,
  parameter int M             = 2,
  parameter int DIN_WIDTH     = 8,
  parameter int K_MAX         = 16,
  parameter int ACC_WIDTH     = 2 * DIN_WIDTH + $clog2(K_MAX),
  parameter int OUT_WIDTH     = 2 * DIN_WIDTH,
  parameter int OUT_BUS_WIDTH = N * OUT_WIDTH,
  parameter int ROW_WIDTH     = row_idx_width(M)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_sa_done,
  input  logic [M*N*ACC_WIDTH-1:0]   i_sa_acc,
  output logic                       o_sa_hold,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUT_BUS_WIDTH-1:0]   o_data,
  output logic [ROW_WIDTH-1:0]       o_row,
  output logic                       o_last,
  output logic                       o_overrun,
  input  logic                       i_clr_err
);

  localparam int                   ROW_BITS = N * ACC_WIDTH;
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(M - 1);

  drain_state_e                 state;
  logic [ROW_WIDTH-1:0]         row;
  logic [M*N*ACC_WIDTH-1:0]     cap_buf;
  logic                         overrun;
  logic                         draining;
  logic                         accept;
  int                           row_base;
  logic [ROW_BITS-1:0]          acc_row;
  logic [OUT_BUS_WIDTH-1:0]     sat_row;

  assign draining = (state == DRAIN);
  assign accept   = (state == IDLE) && i_sa_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_sa_done) begin
            state <= DRAIN;
            row   <= '0;
          end
        end
        DRAIN: begin
          if (i_ready) begin
            if (row == LAST_ROW) begin
              state <= IDLE;
              row   <= '0;
            end else begin
              row <= row + ROW_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          row   <= '0;
        end
      endcase
    end
  end

  // NOTE: the capture buffer is deliberately left out of reset; its contents
  // are only observable while draining, which always follows a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_buf <= i_sa_acc;
    end
  end

  // A done pulse seen while draining (including on the final beat) is
  // dropped and flagged; setting beats clearing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (i_sa_done && draining) begin
      overrun <= 1'b1;
    end else if (i_clr_err) begin
      overrun <= 1'b0;
    end
  end

  // Select the current row out of the held matrix and saturate per column.
  assign row_base = int'(row) * ROW_BITS;
  assign acc_row  = cap_buf[row_base +: ROW_BITS];

  generate
    for (genvar c = 0; c < N; c++) begin : g_col
      sa_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
      ) u_sat (
        .acc (acc_row[c*ACC_WIDTH +: ACC_WIDTH]),
        .sat (sat_row[c*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate

  assign o_valid   = draining;
  assign o_sa_hold = draining;
  assign o_row     = row;
  assign o_last    = draining && (row == LAST_ROW);
  assign o_overrun = overrun;
  // Data bus reads zero outside a beat so the unreset buffer never leaks out.
  assign o_data    = draining ? sat_row : '0;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: a 2x2 instance for the main scenarios
// and a 3x3 instance for the larger-array repeat of the basic scenario.
module tb_sa_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 2x2 instance
  logic         a_done  = 1'b0;
  logic [79:0]  a_acc   = '0;
  logic         a_ready = 1'b0;
  logic         a_clr   = 1'b0;
  logic         a_hold, a_valid, a_last, a_overrun;
  logic [31:0]  a_data;
  logic [0:0]   a_row;

  // 3x3 instance
  logic         b_done  = 1'b0;
  logic [179:0] b_acc   = '0;
  logic         b_ready = 1'b0;
  logic         b_clr   = 1'b0;
  logic         b_hold, b_valid, b_last, b_overrun;
  logic [47:0]  b_data;
  logic [1:0]   b_row;

  int total = 0;
  int bad   = 0;

  sa_result_drain #(.N(2), .M(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .i_sa_done (a_done),
    .i_sa_acc  (a_acc),
    .o_sa_hold (a_hold),
    .o_valid   (a_valid),
    .i_ready   (a_ready),
    .o_data    (a_data),
    .o_row     (a_row),
    .o_last    (a_last),
    .o_overrun (a_overrun),
    .i_clr_err (a_clr)
  );

  sa_result_drain #(.N(3), .M(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .i_sa_done (b_done),
    .i_sa_acc  (b_acc),
    .o_sa_hold (b_hold),
    .o_valid   (b_valid),
    .i_ready   (b_ready),
    .o_data    (b_data),
    .o_row     (b_row),
    .o_last    (b_last),
    .o_overrun (b_overrun),
    .i_clr_err (b_clr)
  );

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled a further 1 time unit later, far from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pack2(int a00, int a01, int a10, int a11);
    logic [79:0] r;
    r = '0;
    r[0  +: 20] = 20'(a00);
    r[20 +: 20] = 20'(a01);
    r[40 +: 20] = 20'(a10);
    r[60 +: 20] = 20'(a11);
    return r;
  endfunction

  function automatic logic [179:0] pack3(input int e [9]);
    logic [179:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*20 +: 20] = 20'(e[i]);
    return r;
  endfunction

  function automatic logic [31:0] row2(int c0, int c1);
    return {16'(c1), 16'(c0)};
  endfunction

  function automatic logic [47:0] row3(int c0, int c1, int c2);
    return {16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic logic [36:0] snap_a();
    return {a_valid, a_hold, a_last, a_overrun, a_row, a_data};
  endfunction

  function automatic logic [36:0] exp_a(logic v, logic h, logic l, logic ov,
                                        logic [0:0] r, logic [31:0] d);
    return {v, h, l, ov, r, d};
  endfunction

  function automatic logic [53:0] snap_b();
    return {b_valid, b_hold, b_last, b_overrun, b_row, b_data};
  endfunction

  function automatic logic [53:0] exp_b(logic v, logic h, logic l, logic ov,
                                        logic [1:0] r, logic [47:0] d);
    return {v, h, l, ov, r, d};
  endfunction

  // Field order in the hex dumps: valid,hold,last,overrun,row,data.
  task automatic test_reset();
    logic [36:0] e;
    rst = 1'b1;
    tick();
    tick();
    #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin
      bad++; $display("FAIL reset_a got=%h want=%h", snap_a(), e);
    end
    total++;
    if (snap_b() !== 54'h0) begin
      bad++; $display("FAIL reset_b got=%h want=%h", snap_b(), 54'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [36:0] e;
    tick(); a_done = 1'b1; a_acc = pack2(1, -2, 300, -400); a_ready = 1'b1; #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL basic_idle got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(1, -2));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL basic_row0 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(300, -400));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL basic_row1 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL basic_release got=%h want=%h", snap_a(), e); end
  endtask

  task automatic test_saturation();
    logic [36:0] e;
    tick(); a_done = 1'b1; a_acc = pack2(40000, -40000, 32767, -32768); a_ready = 1'b1; #1;
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(32767, -32768));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL sat_row0 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(32767, -32768));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL sat_row1 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL sat_release got=%h want=%h", snap_a(), e); end
  endtask

  task automatic test_backpressure();
    logic [36:0] e0, e1, ei;
    e0 = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(5, -6));
    e1 = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(7, -8));
    ei = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); a_done = 1'b1; a_acc = pack2(5, -6, 7, -8); a_ready = 1'b0; #1;
    tick(); a_done = 1'b0; #1;
    // Five stalled cycles on row 0 (this one plus four more).
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); #1; end
      total++;
      if (snap_a() !== e0) begin bad++; $display("FAIL bp_hold%0d got=%h want=%h", i, snap_a(), e0); end
    end
    tick(); a_ready = 1'b1; #1;
    total++;
    if (snap_a() !== e0) begin bad++; $display("FAIL bp_row0_xfer got=%h want=%h", snap_a(), e0); end
    tick(); a_ready = 1'b0; #1;
    total++;
    if (snap_a() !== e1) begin bad++; $display("FAIL bp_row1_stall got=%h want=%h", snap_a(), e1); end
    tick(); a_ready = 1'b1; #1;
    total++;
    if (snap_a() !== e1) begin bad++; $display("FAIL bp_row1_xfer got=%h want=%h", snap_a(), e1); end
    tick(); #1;
    total++;
    if (snap_a() !== ei) begin bad++; $display("FAIL bp_release got=%h want=%h", snap_a(), ei); end
  endtask

  task automatic test_overrun();
    logic [36:0] e;
    tick(); a_done = 1'b1; a_acc = pack2(10, 20, 30, 40); a_ready = 1'b0; #1;
    tick(); a_done = 1'b1; a_acc = pack2(-1, -1, -1, -1); #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(10, 20));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_first got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b1; a_clr = 1'b1; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, row2(10, 20));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_flag got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b0; a_clr = 1'b1; #1;
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_set_beats_clr got=%h want=%h", snap_a(), e); end
    tick(); a_clr = 1'b0; a_ready = 1'b1; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(10, 20));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_clear got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(30, 40));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_row1 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL ovr_release got=%h want=%h", snap_a(), e); end
  endtask

  task automatic test_boundary();
    logic [36:0] e;
    tick(); a_done = 1'b1; a_acc = pack2(1, 2, 3, 4); a_ready = 1'b1; #1;
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(1, 2));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_row0 got=%h want=%h", snap_a(), e); end
    // Done on the final-transfer cycle: dropped and flagged.
    tick(); a_done = 1'b1; a_acc = pack2(99, 99, 99, 99); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(3, 4));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_row1 got=%h want=%h", snap_a(), e); end
    // Done one cycle later, in IDLE: accepted.
    tick(); a_done = 1'b1; a_acc = pack2(-5, 6, -7, 8); #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_dropped got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, row2(-5, 6));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_next_row0 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, row2(-7, 8));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_next_row1 got=%h want=%h", snap_a(), e); end
    tick(); a_clr = 1'b1; #1;
    tick(); a_clr = 1'b0; #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL bnd_clear got=%h want=%h", snap_a(), e); end
  endtask

  task automatic test_reset_mid_drain();
    logic [36:0] e;
    tick(); a_done = 1'b1; a_acc = pack2(11, 12, 13, 14); a_ready = 1'b1; #1;
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(11, 12));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_row0 got=%h want=%h", snap_a(), e); end
    tick(); rst = 1'b1; a_ready = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(13, 14));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_row1 got=%h want=%h", snap_a(), e); end
    tick(); rst = 1'b0; #1;
    e = exp_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_abandon got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b1; a_acc = pack2(21, 22, 23, 24); a_ready = 1'b1; #1;
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_quiet got=%h want=%h", snap_a(), e); end
    tick(); a_done = 1'b0; #1;
    e = exp_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, row2(21, 22));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_restart_row0 got=%h want=%h", snap_a(), e); end
    tick(); #1;
    e = exp_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, row2(23, 24));
    total++;
    if (snap_a() !== e) begin bad++; $display("FAIL rmd_restart_row1 got=%h want=%h", snap_a(), e); end
    tick(); #1;
  endtask

  task automatic test_basic_3x3();
    logic [53:0] e;
    int vals [9];
    vals = '{1, -2, 3, 300, -400, 500, -7, 40000, -40000};
    tick(); b_done = 1'b1; b_acc = pack3(vals); b_ready = 1'b1; #1;
    tick(); b_done = 1'b0; #1;
    e = exp_b(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, row3(1, -2, 3));
    total++;
    if (snap_b() !== e) begin bad++; $display("FAIL b3_row0 got=%h want=%h", snap_b(), e); end
    tick(); #1;
    e = exp_b(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, row3(300, -400, 500));
    total++;
    if (snap_b() !== e) begin bad++; $display("FAIL b3_row1 got=%h want=%h", snap_b(), e); end
    tick(); #1;
    e = exp_b(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, row3(-7, 32767, -32768));
    total++;
    if (snap_b() !== e) begin bad++; $display("FAIL b3_row2 got=%h want=%h", snap_b(), e); end
    tick(); #1;
    e = exp_b(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 48'h0);
    total++;
    if (snap_b() !== e) begin bad++; $display("FAIL b3_release got=%h want=%h", snap_b(), e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_boundary();
    test_reset_mid_drain();
    test_basic_3x3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
